// File: rtl/dmem_arb_pkg.sv
// Shared constants for the data-memory arbiter: owner encoding, bus widths
// and the default DMA starvation limit.
package dmem_arb_pkg;

   localparam logic OWN_CORE       = 1'b0;
   localparam logic OWN_DMA        = 1'b1;

   localparam int   ADDR_W         = 32;
   localparam int   DATA_W         = 32;
   localparam int   STRB_W         = 4;

   localparam int   STARVE_MAX_DEF = 8;

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational winner selection between core and DMA. dma_first carries the
// mode state: the round-robin pointer or the starvation flag.
module dmem_arb_pick (
   input  logic c_req,
   input  logic d_req,
   input  logic dma_first,
   output logic c_win,
   output logic d_win
);

   // dma_first only matters on a conflict; a lone requester always wins
   assign c_win = c_req & (~d_req | ~dma_first);
   assign d_win = d_req & (~c_req |  dma_first);

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port (core/DMA) arbiter in front of a 1-cycle-latency data memory.
// Define DMEM_ARB_RR_EN for round-robin; otherwise core priority with DMA starvation guard.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              c_req,
   input  logic              c_we,
   input  logic [ADDR_W-1:0] c_addr,
   input  logic [DATA_W-1:0] c_wdata,
   input  logic [STRB_W-1:0] c_wstrb,
   output logic              c_gnt,
   output logic              c_rvalid,
   output logic [DATA_W-1:0] c_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   input  logic [STRB_W-1:0] d_wstrb,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              m_re,
   output logic [ADDR_W-1:0] m_raddr,
   output logic              m_we,
   output logic [ADDR_W-1:0] m_waddr,
   output logic [DATA_W-1:0] m_wdata,
   output logic [STRB_W-1:0] m_wstrb,
   input  logic [DATA_W-1:0] m_rdata
);

   logic              dma_first;
   logic              c_win;
   logic              d_win;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [STRB_W-1:0] sel_wstrb;
   logic              owner_reg;
   logic              pend_reg;
   logic [DATA_W-1:0] c_hold_reg;
   logic [DATA_W-1:0] d_hold_reg;

`ifdef DMEM_ARB_RR_EN
   // Pointer names the port that wins the next conflict
   logic rr_ptr_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     rr_ptr_reg <= OWN_CORE;
      else if (c_gnt) rr_ptr_reg <= OWN_DMA;
      else if (d_gnt) rr_ptr_reg <= OWN_CORE;
   end

   assign dma_first = (rr_ptr_reg == OWN_DMA);
`else
   localparam int              CNT_W   = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0] starve_cnt_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                     starve_cnt_reg <= '0;
      else if (!d_req || d_gnt)       starve_cnt_reg <= '0;
      else if (starve_cnt_reg != CNT_MAX) starve_cnt_reg <= starve_cnt_reg + CNT_W'(1);
   end

   assign dma_first = (starve_cnt_reg == CNT_MAX);
`endif

   dmem_arb_pick u_pick (
      .c_req     (c_req),
      .d_req     (d_req),
      .dma_first (dma_first),
      .c_win     (c_win),
      .d_win     (d_win)
   );

   // Grants are forced low while reset is held, even with requests pending
   assign c_gnt = rst_n & c_win;
   assign d_gnt = rst_n & d_win;

   assign sel_we    = d_win ? d_we    : c_we;
   assign sel_addr  = d_win ? d_addr  : c_addr;
   assign sel_wdata = d_win ? d_wdata : c_wdata;
   assign sel_wstrb = d_win ? d_wstrb : c_wstrb;

   always_comb begin
      m_re    = 1'b0;
      m_raddr = '0;
      m_we    = 1'b0;
      m_waddr = '0;
      m_wdata = '0;
      m_wstrb = '0;
      if (c_gnt || d_gnt) begin
         if (sel_we) begin
            m_we    = 1'b1;
            m_waddr = sel_addr;
            m_wdata = sel_wdata;
            m_wstrb = sel_wstrb;
         end else begin
            m_re    = 1'b1;
            m_raddr = sel_addr;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_reg  <= 1'b0;
         owner_reg <= OWN_CORE;
      end else begin
         pend_reg <= (c_gnt || d_gnt) && !sel_we;
         if ((c_gnt || d_gnt) && !sel_we)
            owner_reg <= d_gnt ? OWN_DMA : OWN_CORE;
      end
   end

   assign c_rvalid = pend_reg && (owner_reg == OWN_CORE);
   assign d_rvalid = pend_reg && (owner_reg == OWN_DMA);

   // Memory data is live only during rvalid; the hold registers keep it afterwards
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         c_hold_reg <= '0;
         d_hold_reg <= '0;
      end else begin
         if (c_rvalid) c_hold_reg <= m_rdata;
         if (d_rvalid) d_hold_reg <= m_rdata;
      end
   end

   assign c_rdata = c_rvalid ? m_rdata : c_hold_reg;
   assign d_rdata = d_rvalid ? m_rdata : d_hold_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small byte-writable memory model.
// Exercises the core-priority build, or round-robin when DMEM_ARB_RR_EN is defined.
module tb_dmem_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        c_req, c_we, d_req, d_we;
   logic [31:0] c_addr, c_wdata, d_addr, d_wdata;
   logic [3:0]  c_wstrb, d_wstrb;
   logic        c_gnt, c_rvalid, d_gnt, d_rvalid;
   logic [31:0] c_rdata, d_rdata;
   logic        m_re, m_we;
   logic [31:0] m_raddr, m_waddr, m_wdata, m_rdata;
   logic [3:0]  m_wstrb;

   int checks = 0;
   int errors = 0;

   logic [31:0] mem [0:255];

   always #5 clk = ~clk;

   dmem_arbiter #(.STARVE_MAX(8)) dut (
      .clk(clk), .rst_n(rst_n),
      .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata), .c_wstrb(c_wstrb),
      .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .m_re(m_re), .m_raddr(m_raddr), .m_we(m_we), .m_waddr(m_waddr),
      .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
   );

   // Data memory: 1-cycle read latency, byte-enabled writes
   always @(posedge clk) begin
      if (m_we)
         for (int b = 0; b < 4; b++)
            if (m_wstrb[b]) mem[m_waddr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
      if (m_re) m_rdata <= mem[m_raddr[9:2]];
   end

   task automatic idle();
      c_req = 0; c_we = 0; c_addr = 0; c_wdata = 0; c_wstrb = 0;
      d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0; d_wstrb = 0;
   endtask

   task automatic do_reset();
      idle();
      rst_n = 0;
      @(negedge clk);
      @(negedge clk);
      rst_n = 1;
   endtask

   task automatic test_reset();
      rst_n = 0;
      c_req = 1; c_addr = 32'h10; d_req = 1; d_addr = 32'h14;
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we} !== 6'b0)
         $display("FAIL reset_ctrl: got %b expected 000000", {c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we});
      checks++;
      if ({c_rdata, d_rdata} !== 64'h0)
         $display("FAIL reset_rdata: got %h expected 0", {c_rdata, d_rdata});
      checks++;
      if ({m_raddr, m_waddr, m_wdata, m_wstrb} !== 100'h0)
         $display("FAIL reset_mem_bus: got %h expected 0", {m_raddr, m_waddr, m_wdata, m_wstrb});
      if ({c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we} !== 6'b0 || {c_rdata, d_rdata} !== 64'h0
          || {m_raddr, m_waddr, m_wdata, m_wstrb} !== 100'h0) errors++;
      idle();
      @(negedge clk);
      rst_n = 1;
      $display("test_reset done");
   endtask

   task automatic test_idle();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if ({c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we} !== 6'b0) begin
            errors++;
            $display("FAIL idle_%0d: got %b expected 000000", i, {c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we});
         end
      end
      $display("test_idle: 5 idle cycles");
   endtask

   task automatic test_core_read();
      @(posedge clk); #1;
      c_req = 1; c_we = 0; c_addr = 32'h10;
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt, m_re, m_we} !== 4'b1010 || m_raddr !== 32'h10) begin
         errors++;
         $display("FAIL core_read_gnt: got gnt/re/we=%b raddr=%h expected 1010 raddr=00000010",
                  {c_gnt, d_gnt, m_re, m_we}, m_raddr);
      end
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if ({c_rvalid, d_rvalid} !== 2'b10 || c_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL core_read_data: got rvalid=%b rdata=%h expected 10 deadbeef", {c_rvalid, d_rvalid}, c_rdata);
      end
      @(negedge clk);
      checks++;
      if ({c_rvalid, d_rvalid} !== 2'b00 || c_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL core_read_hold: got rvalid=%b rdata=%h expected 00 deadbeef", {c_rvalid, d_rvalid}, c_rdata);
      end
      $display("test_core_read: addr 0x10 -> %h", c_rdata);
   endtask

   task automatic test_raw();
      @(posedge clk); #1;
      d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h55; d_wstrb = 4'b0001;
      @(negedge clk);
      checks++;
      if ({c_gnt, d_gnt, m_re, m_we} !== 4'b0101) begin
         errors++;
         $display("FAIL dma_write_gnt: got %b expected 0101", {c_gnt, d_gnt, m_re, m_we});
      end
      checks++;
      if ({m_waddr, m_wdata, m_wstrb} !== {32'h20, 32'h55, 4'b0001}) begin
         errors++;
         $display("FAIL dma_write_bus: got %h/%h/%b expected 00000020/00000055/0001", m_waddr, m_wdata, m_wstrb);
      end
      @(posedge clk); #1;
      idle();
      c_req = 1; c_addr = 32'h20;
      @(negedge clk);
      checks++;
      if ({c_gnt, m_re, d_rvalid, c_rvalid} !== 4'b1100) begin
         errors++;
         $display("FAIL raw_read_gnt: got gnt/re/drv/crv=%b expected 1100", {c_gnt, m_re, d_rvalid, c_rvalid});
      end
      @(posedge clk); #1;
      idle();
      @(negedge clk);
      checks++;
      if (c_rvalid !== 1'b1 || c_rdata !== 32'h11223355) begin
         errors++;
         $display("FAIL raw_read_data: got rvalid=%b rdata=%h expected 1 11223355", c_rvalid, c_rdata);
      end
      $display("test_raw: write 0x55 strb 0001 @0x20 then read -> %h", c_rdata);
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp [0:2];
      exp[0] = 32'h0000_1111; exp[1] = 32'h2222_0000; exp[2] = 32'h3333_3333;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         idle();
         if (i < 3) begin c_req = 1; c_addr = 32'h30 + 32'(4 * i); end
         @(negedge clk);
         if (i < 3) begin
            checks++;
            if (c_gnt !== 1'b1 || m_re !== 1'b1 || m_raddr !== 32'h30 + 32'(4 * i)) begin
               errors++;
               $display("FAIL b2b_gnt_%0d: got gnt=%b re=%b raddr=%h expected 1 1 %h",
                        i, c_gnt, m_re, m_raddr, 32'h30 + 32'(4 * i));
            end
         end
         if (i > 0) begin
            checks++;
            if (c_rvalid !== 1'b1 || c_rdata !== exp[i-1]) begin
               errors++;
               $display("FAIL b2b_data_%0d: got rvalid=%b rdata=%h expected 1 %h", i, c_rvalid, c_rdata, exp[i-1]);
            end
         end
      end
      $display("test_back_to_back: 3 consecutive core reads");
   endtask

`ifdef DMEM_ARB_RR_EN
   task automatic test_rr();
      logic [1:0] exp_gnt, exp_rv;
      do_reset();
      for (int i = 1; i <= 5; i++) begin
         @(posedge clk); #1;
         idle();
         if (i <= 4) begin c_req = 1; c_addr = 32'h0; d_req = 1; d_addr = 32'h4; end
         exp_gnt = (i > 4) ? 2'b00 : ((i % 2) == 1) ? 2'b10 : 2'b01;
         exp_rv  = (i == 1) ? 2'b00 : ((i % 2) == 0) ? 2'b10 : 2'b01;
         @(negedge clk);
         checks++;
         if ({c_gnt, d_gnt} !== exp_gnt) begin
            errors++;
            $display("FAIL rr_gnt_%0d: got %b expected %b", i, {c_gnt, d_gnt}, exp_gnt);
         end
         checks++;
         if ({c_rvalid, d_rvalid} !== exp_rv
             || (exp_rv[1] && c_rdata !== 32'hA0A0A0A0) || (exp_rv[0] && d_rdata !== 32'hB1B1B1B1)) begin
            errors++;
            $display("FAIL rr_rvalid_%0d: got %b c=%h d=%h expected %b", i, {c_rvalid, d_rvalid}, c_rdata, d_rdata, exp_rv);
         end
         $display("rr cycle %0d: gnt=%b rvalid=%b", i, {c_gnt, d_gnt}, {c_rvalid, d_rvalid});
      end
   endtask
`else
   task automatic test_starve();
      logic [1:0] exp_gnt, exp_rv;
      @(posedge clk); #1;
      idle();
      c_req = 1; c_addr = 32'h0; d_req = 1; d_addr = 32'h4;
      for (int i = 1; i <= 19; i++) begin
         exp_gnt = (i == 9 || i == 18) ? 2'b01 : 2'b10;
         exp_rv  = (i == 1) ? 2'b00 : (i == 10 || i == 19) ? 2'b01 : 2'b10;
         @(negedge clk);
         checks++;
         if ({c_gnt, d_gnt} !== exp_gnt) begin
            errors++;
            $display("FAIL starve_gnt_%0d: got %b expected %b", i, {c_gnt, d_gnt}, exp_gnt);
         end
         checks++;
         if ({c_rvalid, d_rvalid} !== exp_rv
             || (exp_rv[1] && c_rdata !== 32'hA0A0A0A0) || (exp_rv[0] && d_rdata !== 32'hB1B1B1B1)) begin
            errors++;
            $display("FAIL starve_rvalid_%0d: got %b c=%h d=%h expected %b", i, {c_rvalid, d_rvalid}, c_rdata, d_rdata, exp_rv);
         end
         $display("starve cycle %0d: gnt=%b rvalid=%b", i, {c_gnt, d_gnt}, {c_rvalid, d_rvalid});
         @(posedge clk); #1;
      end
      idle();
   endtask
`endif

   task automatic test_reset_mid();
      @(posedge clk); #1;
      idle();
      c_req = 1; c_addr = 32'h10;
      @(negedge clk);
      checks++;
      if (c_gnt !== 1'b1) begin
         errors++;
         $display("FAIL rstmid_gnt: got %b expected 1", c_gnt);
      end
      @(posedge clk); #1;
      rst_n = 0;
      d_req = 1; d_addr = 32'h14;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we} !== 6'b0 || {c_rdata, d_rdata} !== 64'h0) begin
            errors++;
            $display("FAIL rstmid_out_%0d: got ctrl=%b c=%h d=%h expected 000000 0 0",
                     i, {c_gnt, d_gnt, c_rvalid, d_rvalid, m_re, m_we}, c_rdata, d_rdata);
         end
      end
      idle();
      rst_n = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if ({c_rvalid, d_rvalid} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_post_%0d: got %b expected 00", i, {c_rvalid, d_rvalid});
         end
      end
      $display("test_reset_mid: read dropped by reset");
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[0]  = 32'hA0A0A0A0;
      mem[1]  = 32'hB1B1B1B1;
      mem[4]  = 32'hDEADBEEF;
      mem[8]  = 32'h11223300;
      mem[12] = 32'h0000_1111;
      mem[13] = 32'h2222_0000;
      mem[14] = 32'h3333_3333;
      m_rdata = 32'h0;
      idle();
      test_reset();
      test_idle();
      test_core_read();
      test_raw();
      test_back_to_back();
`ifdef DMEM_ARB_RR_EN
      test_rr();
`else
      test_starve();
`endif
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 The module SHALL use one clock and an asynchronous, active-low reset.
REQ-002 Parameter STARVE_MAX SHALL default to 8 and SHALL be the core-priority wait limit for the DMA port, in cycles.
REQ-003 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-004 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-005 Ports c_req and d_req, input, 1 bit each, SHALL be the core and DMA access requests.
REQ-006 Ports c_we and d_we, input, 1 bit each, SHALL mark the request as a write (1) or a read (0).
REQ-007 Ports c_addr and d_addr, input, 32 bits each, SHALL carry the byte address.
REQ-008 Ports c_wdata and d_wdata, input, 32 bits each, SHALL carry the write data.
REQ-009 Ports c_wstrb and d_wstrb, input, 4 bits each, SHALL carry the byte write enables.
REQ-010 Ports c_gnt and d_gnt, output, 1 bit each, SHALL signal that the request is accepted this cycle.
REQ-011 Ports c_rvalid and d_rvalid, output, 1 bit each, SHALL signal that read data is valid.
REQ-012 Ports c_rdata and d_rdata, output, 32 bits each, SHALL carry the returned read data.
REQ-013 Ports m_re, m_raddr[31:0], m_we, m_waddr[31:0], m_wdata[31:0] and m_wstrb[3:0], outputs, SHALL drive the data memory.
REQ-014 Port m_rdata, input, 32 bits, SHALL carry the data memory read data, which has 1-cycle latency.

Function
REQ-015 At most one of c_gnt and d_gnt SHALL be high in any cycle.
REQ-016 A grant SHALL be asserted combinationally in the same cycle as the winning req; an access completes when req and gnt are both high.
REQ-017 For a granted read, m_re SHALL be 1, m_raddr SHALL equal the winner's addr, and m_we SHALL be 0.
REQ-018 For a granted write, m_we SHALL be 1, m_waddr, m_wdata and m_wstrb SHALL equal the winner's fields, and m_re SHALL be 0.
REQ-019 With no grant, m_re and m_we SHALL be 0; the address and data outputs are don't-care.
REQ-020 A registered owner flag and a pending flag SHALL capture every granted read; in the following cycle exactly the owner's rvalid SHALL pulse for 1 cycle, with rdata equal to m_rdata.
REQ-021 Read latency SHALL be exactly 1 cycle from grant to rvalid, and back-to-back reads SHALL be accepted every cycle with no bubble.
REQ-022 Writes SHALL produce no rvalid.
REQ-023 A rdata output SHALL hold its last value whenever its rvalid is 0.
REQ-024 A requester SHALL hold req and all its fields stable until granted; the arbiter need not check this.
REQ-025 Read-after-write to the same word in consecutive cycles SHALL return the new data, relying on data memory ordering with no extra stall.
REQ-026 The arbiter SHALL keep no FSM beyond the arbitration state (the rr pointer or the starvation counter), the owner flag and the pending flag.

Reset
REQ-027 While rst_n is low, all outputs SHALL be 0: gnt, rvalid, m_re and m_we immediately, rdata cleared.
REQ-028 Reset SHALL clear the owner flag, the pending flag, the starvation counter and the rr pointer (pointing to core).
REQ-029 A read granted in the cycle before reset assertion SHALL NOT produce an rvalid after reset release.

Configuration
REQ-030 Macro DMEM_ARB_RR_EN, when defined, SHALL select round-robin arbitration: on conflict, the port not granted last SHALL win, and the pointer SHALL update only on a grant.
REQ-031 Without DMEM_ARB_RR_EN, arbitration SHALL be core-priority: the core wins on conflict.
REQ-032 In core-priority mode, a starvation counter SHALL increment each cycle d_req is high and d_gnt is low, and SHALL clear on d_gnt or when d_req is low.
REQ-033 In core-priority mode, when the starvation counter equals STARVE_MAX, the DMA port SHALL win the next conflict.
REQ-034 The counter SHALL saturate at STARVE_MAX, and its width SHALL be $clog2(STARVE_MAX+1).

Structure
REQ-035 Package dmem_arb_pkg SHALL hold the owner encoding (OWN_CORE=0, OWN_DMA=1), the ADDR_W=32, DATA_W=32 and STRB_W=4 constants, and the default STARVE_MAX.
REQ-036 The only sub-module SHALL be dmem_arb_pick: the combinational winner selection from req, the mode state and the starvation flag; the registers SHALL stay in dmem_arbiter.

Verification
REQ-037 Scenario: core read of 0x10 alone, then a word 0xDEADBEEF at 0x10 -> c_gnt the same cycle, c_rvalid the next cycle with c_rdata=0xDEADBEEF, and d_rvalid=0.
REQ-038 Scenario: core and DMA read every cycle for 4 cycles with RR enabled -> grants alternate C,D,C,D, and each rvalid follows its grant by 1 cycle to the correct port.
REQ-039 Scenario: core-priority mode, core requests continuously and DMA requests continuously with STARVE_MAX=8 -> d_gnt asserts on the 9th cycle of waiting, then the core resumes.
REQ-040 Scenario: DMA write of 0x55 with wstrb=0001 to 0x20, then a core read of 0x20 the next cycle -> c_rdata[7:0]=0x55.
REQ-041 Scenario: rst_n asserted one cycle after a granted read -> no rvalid at any point, and all outputs 0 until release.
REQ-042 Scenario: no requests for 5 cycles -> m_re=m_we=0, both gnt=0, both rvalid=0.
